// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : systolic_pkg
//  Description : Shared types and sizing helpers for the weight-stationary
//                systolic matrix-vector engine.
//                  state_t  - controller state encoding
//                  lat(n)   - vector latency in cycles (accept edge to y_out)
//                  cnt_w(n) - width of the in-flight vector counter
//  Revision    : 1.0 - parametrised N x N successor of the fixed 4x4 array
// ============================================================================
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  function automatic int lat(input int n);
    return 2 * n;
  endfunction

  // Counter must hold 0..lat(n) inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(2 * n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_pe.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_pe
//  Description : One processing element of the weight-stationary array.
//                Holds a weight, forwards the activation one column to the
//                right and the partial sum one row down, each registered.
//                  psum_out <= psum_in + a_in * weight   (mod 2^ACC_W)
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                w_load, w_in    - weight register load strobe / value
//                a_in, a_out     - activation in from left / out to right
//                psum_in,psum_out- partial sum in from above / out below
//  Config      : SYSTOLIC_SIGNED_EN - when defined, a and weight are two's
//                complement and the product is sign-extended to ACC_W;
//                otherwise both are zero-extended.
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_load,
  input  logic [DATA_W-1:0] w_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic [ACC_W-1:0]  psum_in,
  output logic [DATA_W-1:0] a_out,
  output logic [ACC_W-1:0]  psum_out
);

  logic [DATA_W-1:0] weight;
  logic [ACC_W-1:0]  a_ext;
  logic [ACC_W-1:0]  w_ext;

  // Extending both operands to ACC_W before multiplying makes the low ACC_W
  // bits of the product equal the true 2*DATA_W product extended to ACC_W.
`ifdef SYSTOLIC_SIGNED_EN
  assign a_ext = {{(ACC_W-DATA_W){a_in[DATA_W-1]}}, a_in};
  assign w_ext = {{(ACC_W-DATA_W){weight[DATA_W-1]}}, weight};
`else
  assign a_ext = {{(ACC_W-DATA_W){1'b0}}, a_in};
  assign w_ext = {{(ACC_W-DATA_W){1'b0}}, weight};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      weight   <= '0;
      a_out    <= '0;
      psum_out <= '0;
    end else begin
      if (w_load) weight <= w_in;
      a_out    <= a_in;
      psum_out <= psum_in + a_ext * w_ext;
    end
  end

endmodule
`default_nettype wire

// File: rtl/systolic_mm_array.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_mm_array
//  Description : N x N weight-stationary systolic matrix-vector engine.
//                y[j] = sum_i a[i]*W[i][j] mod 2^ACC_W. Weights load one row
//                per cycle; activation vectors stream in unskewed, are skewed
//                internally and results are deskewed so each y vector
//                appears in one cycle, 2*N cycles after acceptance.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                w_valid/w_ready     - weight row handshake (reload request
//                                      while running)
//                w_data              - weight row, element j at j*DATA_W
//                in_valid/in_ready   - activation vector handshake
//                a_in                - activation vector, element i at i*DATA_W
//                out_valid, y_out    - one-cycle result strobe / result vector
//                busy                - high in LOAD, RUN and DRAIN
//  Config      : SYSTOLIC_SIGNED_EN selects signed arithmetic in the PEs.
//  Revision    : 1.0 - parametrised N x N successor of the fixed 4x4 array
// ============================================================================
module systolic_mm_array
  import systolic_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [N*DATA_W-1:0] w_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] a_in,
  output logic                out_valid,
  output logic [N*ACC_W-1:0]  y_out,
  output logic                busy
);

  localparam int LAT = lat(N);
  localparam int CW  = cnt_w(N);
  localparam int RW  = $clog2(N);

  state_t         state, state_nxt;
  logic [RW-1:0]  row_cnt;
  logic [CW-1:0]  in_flight;
  logic [LAT-1:0] vpipe;
  logic           w_fire, in_fire;
  logic [N-1:0]   row_load;

  logic [DATA_W-1:0] a_link    [N][N];
  logic [DATA_W-1:0] a_unused  [N];
  logic [ACC_W-1:0]  psum_link [N+1][N];
  logic [ACC_W-1:0]  col_aligned [N];

  assign w_fire  = w_valid && w_ready;
  assign in_fire = in_valid && in_ready;

  // ---------------- controller ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    w_ready   = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        w_ready = 1'b1;
        busy    = 1'b0;
        if (w_valid) state_nxt = LOAD;
      end
      LOAD: begin
        w_ready = 1'b1;
        if (w_valid && row_cnt == RW'(N-1)) state_nxt = RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        // Reload request: w_valid is not consumed here, only noted.
        if (w_valid) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (in_flight == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt <= '0;
    end else if (w_fire) begin
      row_cnt <= (row_cnt == RW'(N-1)) ? '0 : row_cnt + RW'(1);
    end
  end

  // Decrement coincides with the edge that raises out_valid, so at most LAT
  // vectors are ever counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight <= '0;
    end else begin
      case ({in_fire, vpipe[LAT-1]})
        2'b10:   in_flight <= in_flight + CW'(1);
        2'b01:   in_flight <= in_flight - CW'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe     <= '0;
      out_valid <= 1'b0;
    end else begin
      vpipe     <= {vpipe[LAT-2:0], in_fire};
      out_valid <= vpipe[LAT-1];
    end
  end

  // ---------------- input skew: row i delayed by i+1 registers ----------------
  for (genvar i = 0; i < N; i++) begin : g_row
    logic [DATA_W-1:0] skew [i+1];

    assign row_load[i] = w_fire && (row_cnt == RW'(i));

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k <= i; k++) skew[k] <= '0;
      end else begin
        // Bubbles inject zeros so idle wavefronts carry no stale data.
        skew[0] <= in_fire ? a_in[i*DATA_W +: DATA_W] : '0;
        for (int k = 1; k <= i; k++) skew[k] <= skew[k-1];
      end
    end

    assign a_link[i][0] = skew[i];
  end

  for (genvar j = 0; j < N; j++) begin : g_top
    assign psum_link[0][j] = '0;
  end

  // ---------------- PE grid ----------------
  for (genvar i = 0; i < N; i++) begin : g_pe_row
    for (genvar j = 0; j < N; j++) begin : g_pe_col
      if (j == N-1) begin : g_last
        systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
          .clk      (clk),
          .rst      (rst),
          .w_load   (row_load[i]),
          .w_in     (w_data[j*DATA_W +: DATA_W]),
          .a_in     (a_link[i][j]),
          .psum_in  (psum_link[i][j]),
          .a_out    (a_unused[i]),
          .psum_out (psum_link[i+1][j])
        );
      end else begin : g_mid
        systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
          .clk      (clk),
          .rst      (rst),
          .w_load   (row_load[i]),
          .w_in     (w_data[j*DATA_W +: DATA_W]),
          .a_in     (a_link[i][j]),
          .psum_in  (psum_link[i][j]),
          .a_out    (a_link[i][j+1]),
          .psum_out (psum_link[i+1][j])
        );
      end
    end
  end

  // ---------------- output deskew: column j delayed by N-1-j registers ----------------
  for (genvar j = 0; j < N; j++) begin : g_col
    if (j == N-1) begin : g_direct
      assign col_aligned[j] = psum_link[N][j];
    end else begin : g_delay
      localparam int D = N - 1 - j;
      logic [ACC_W-1:0] dly [D];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < D; k++) dly[k] <= '0;
        end else begin
          dly[0] <= psum_link[N][j];
          for (int k = 1; k < D; k++) dly[k] <= dly[k-1];
        end
      end

      assign col_aligned[j] = dly[D-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_out <= '0;
    end else if (vpipe[LAT-1]) begin
      for (int j = 0; j < N; j++) y_out[j*ACC_W +: ACC_W] <= col_aligned[j];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_mm_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_mm_array
//  Description : Self-checking bench for systolic_mm_array (N=4, 8/16 bit).
//                Expected results are queued when a vector is accepted and
//                compared, value and arrival time, when out_valid fires.
//                Honours SYSTOLIC_SIGNED_EN for the expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_mm_array;

  localparam int  N   = 4;
  localparam int  DW  = 8;
  localparam int  AW  = 16;
  localparam int  LAT = 2 * N;
  localparam time PER = 10;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            w_valid = 1'b0;
  logic            in_valid = 1'b0;
  logic [N*DW-1:0] w_data = '0;
  logic [N*DW-1:0] a_in = '0;
  logic            w_ready, in_ready, out_valid, busy;
  logic [N*AW-1:0] y_out;

  always #5 clk = ~clk;

  systolic_mm_array #(.N(N), .DATA_W(DW), .ACC_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .out_valid (out_valid),
    .y_out     (y_out),
    .busy      (busy)
  );

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [N*AW-1:0] y;
    time             t;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  function automatic logic [N*DW-1:0] v4(input int a0, input int a1, input int a2, input int a3);
    return {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  function automatic logic [N*AW-1:0] y4(input int y0, input int y1, input int y2, input int y3);
    return {y3[15:0], y2[15:0], y1[15:0], y0[15:0]};
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [N*AW-1:0] obs, input logic [N*AW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 identity, 1 all ones, 2 all 255
  task automatic load(input int kind);
    int val;
    int n;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        val = (kind == 0) ? int'(r == c) : (kind == 1) ? 1 : 255;
        w_data[c*DW +: DW] = val[7:0];
      end
      w_valid = 1'b1;
      n = 0;
      while (w_ready !== 1'b1 && n < 64) begin
        step();
        n++;
      end
      if (n >= 64) chk1("w_ready_timeout", w_ready, 1'b1);
      step();
    end
    w_valid = 1'b0;
  endtask

  task automatic send(input logic [N*DW-1:0] v, input logic [N*AW-1:0] exp);
    a_in     = v;
    in_valid = 1'b1;
    chk1("in_ready_at_send", in_ready, 1'b1);
    @(posedge clk);
    sb.push_back('{exp, $time + LAT * PER + 5});
    #1;
    in_valid = 1'b0;
  endtask

  // Result monitor: every out_valid must match the oldest queued expectation,
  // both in value and in the exact cycle it appears.
  always @(negedge clk) begin
    if (out_valid !== 1'b0) begin
      if (sb.size() == 0) begin
        chk1("unexpected_out_valid", out_valid, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        chkv("y_out", y_out, mon_e.y);
        compared++;
        assert ($time === mon_e.t) else begin
          mismatched++;
          $error("FAIL out_time observed=%0t expected=%0t", $time, mon_e.t);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // ---- reset ----
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk1("rst_w_ready", w_ready, 1'b1);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chkv("rst_y_out", y_out, '0);

    // ---- identity ----
    load(0);
    chk1("run_in_ready", in_ready, 1'b1);
    chk1("run_w_ready", w_ready, 1'b0);
    chk1("run_busy", busy, 1'b1);
    send(v4(1, 2, 3, 4), y4(1, 2, 3, 4));
    repeat (LAT + 3) step();

    // ---- all ones, back-to-back ----
    load(1);
    send(v4(1, 0, 0, 0), y4(1, 1, 1, 1));
    send(v4(1, 1, 0, 0), y4(2, 2, 2, 2));
    send(v4(1, 0, 1, 0), y4(2, 2, 2, 2));
    send(v4(0, 0, 1, 0), y4(1, 1, 1, 1));
    repeat (LAT + 3) step();

    // ---- wrap ----
    load(2);
`ifdef SYSTOLIC_SIGNED_EN
    send(v4(255, 255, 255, 255), y4(4, 4, 4, 4));
`else
    send(v4(255, 255, 255, 255), y4(63492, 63492, 63492, 63492));
`endif
    repeat (LAT + 3) step();

    // ---- reload request together with an accepted vector (old weights = 255) ----
    w_data  = v4(1, 1, 1, 1);
    w_valid = 1'b1;
`ifdef SYSTOLIC_SIGNED_EN
    send(v4(1, 2, 3, 4), y4(16'hFFF6, 16'hFFF6, 16'hFFF6, 16'hFFF6));
`else
    send(v4(1, 2, 3, 4), y4(2550, 2550, 2550, 2550));
`endif
    w_valid = 1'b0;
    chk1("drain_in_ready", in_ready, 1'b0);
    chk1("drain_w_ready", w_ready, 1'b0);
    chk1("drain_busy", busy, 1'b1);
    n = 0;
    while (n < 4 * LAT) begin
      @(negedge clk);
      if (out_valid === 1'b1) break;
      n++;
    end
    if (n >= 4 * LAT) begin
      chk1("drain_timeout", out_valid, 1'b1);
    end else begin
      chk1("busy_at_last_out", busy, 1'b1);
      @(negedge clk);
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_w_ready", w_ready, 1'b1);
    end
    @(posedge clk);
    #1;

    // ---- sign handling, identity weights ----
    load(0);
`ifdef SYSTOLIC_SIGNED_EN
    send(v4(-1, 2, -3, 4), y4(16'hFFFF, 16'h0002, 16'hFFFD, 16'h0004));
`else
    send(v4(-1, 2, -3, 4), y4(255, 2, 253, 4));
`endif
    repeat (LAT + 3) step();

    // ---- reset mid-stream ----
    send(v4(1, 1, 1, 1), y4(1, 1, 1, 1));
    send(v4(2, 2, 2, 2), y4(2, 2, 2, 2));
    step();
    step();
    rst = 1'b1;
    sb.delete();
    step();
    rst = 1'b0;
    chk1("mid_rst_out_valid", out_valid, 1'b0);
    chkv("mid_rst_y_out", y_out, '0);
    chk1("mid_rst_w_ready", w_ready, 1'b1);
    chk1("mid_rst_busy", busy, 1'b0);
    a_in     = v4(5, 5, 5, 5);
    in_valid = 1'b1;
    repeat (3) begin
      chk1("mid_rst_in_ready", in_ready, 1'b0);
      step();
    end
    in_valid = 1'b0;
    repeat (2 * LAT) step();

    compared++;
    assert (sb.size() == 0) else begin
      mismatched++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
